// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode enum, LED constants and decode helpers
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        RIGHT  = 2'd0,
        LEFT   = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } e_mode;

    localparam logic [3:0] LED_ALL_OFF = 4'b1111;
    localparam logic [3:0] LED_ALL_ON  = 4'b0000;

    function automatic e_mode next_mode(input e_mode m);
        case (m)
            RIGHT:   return LEFT;
            LEFT:    return BOUNCE;
            BOUNCE:  return BLINK;
            default: return RIGHT;
        endcase
    endfunction

    // LEDs are active-low: only the bit at pos is driven 0.
    function automatic logic [3:0] pos_to_led(input logic [1:0] pos);
        return ~(4'b0001 << pos);
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - board-side signal bundle for the LED mode controller
interface led_mode_ctrl_if;
    logic       btn1;
    logic [3:0] led;
    logic [1:0] mode;

    modport master (output btn1, input led, input mode);
    modport slave  (input btn1, output led, output mode);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce and single-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic             armed_q;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             settle;

    assign differ = (sync2_q != level_q);
    assign settle = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // A press is only armed once a real (post-reset) released level has come
    // through the synchroniser, so a button held across reset gives no pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            armed_q <= 1'b0;
            vld_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            if (vld_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
            press_q <= settle && !sync2_q && armed_q;
            if (!differ || settle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (settle) begin
                level_q <= sync2_q;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button-cycled LED pattern controller (right, left, bounce, blink)
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn1,
    output logic [3:0] led,
    output logic [1:0] mode
);
    localparam int STEP_W = $clog2(STEP_CYCLES);

    logic              press;
    e_mode             mode_q;
    logic [1:0]        pos_q;
    logic              dir_up_q;
    logic              phase_on_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [3:0]        led_q;
    logic [3:0]        led_d;
    logic [1:0]        mode_out_q;
    logic [1:0]        mode_d;
    logic              tick;
    e_mode             mode_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn1),
        .press (press)
    );

    assign tick     = (step_cnt_q == STEP_W'(STEP_CYCLES - 1));
    assign mode_nxt = next_mode(mode_q);
    assign mode_d   = mode_q;

    always_comb begin
        led_d = pos_to_led(pos_q);
        if (mode_q == BLINK) begin
            led_d = phase_on_q ? LED_ALL_ON : LED_ALL_OFF;
        end
    end

    // A press wins over a coincident tick: the step is dropped and the new
    // mode starts a fresh period from its start position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= RIGHT;
            pos_q      <= 2'd0;
            dir_up_q   <= 1'b1;
            phase_on_q <= 1'b1;
            step_cnt_q <= '0;
            led_q      <= LED_ALL_OFF;
            mode_out_q <= 2'd0;
        end else begin
            led_q      <= led_d;
            mode_out_q <= mode_d;
            if (press) begin
                mode_q     <= mode_nxt;
                step_cnt_q <= '0;
                pos_q      <= (mode_nxt == LEFT) ? 2'd3 : 2'd0;
                dir_up_q   <= 1'b1;
                phase_on_q <= 1'b1;
            end else begin
                step_cnt_q <= tick ? '0 : step_cnt_q + STEP_W'(1);
                if (tick) begin
                    case (mode_q)
                        RIGHT: pos_q <= pos_q + 2'd1;
                        LEFT:  pos_q <= pos_q - 2'd1;
                        BOUNCE: begin
                            if (dir_up_q) begin
                                if (pos_q == 2'd3) begin
                                    pos_q    <= 2'd2;
                                    dir_up_q <= 1'b0;
                                end else begin
                                    pos_q <= pos_q + 2'd1;
                                end
                            end else begin
                                if (pos_q == 2'd0) begin
                                    pos_q    <= 2'd1;
                                    dir_up_q <= 1'b1;
                                end else begin
                                    pos_q <= pos_q - 2'd1;
                                end
                            end
                        end
                        default: phase_on_q <= ~phase_on_q;
                    endcase
                end
            end
        end
    end

    assign led  = led_q;
    assign mode = mode_out_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - randomized and directed bench for led_mode_ctrl against a pattern model
module tb_led_mode_ctrl;
    localparam int STEP = 4;
    localparam int DEB  = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    led_mode_ctrl_if intf ();

    led_mode_ctrl #(
        .STEP_CYCLES     (STEP),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn1  (intf.btn1),
        .led   (intf.led),
        .mode  (intf.mode)
    );

    always #5 clk = ~clk;

    // Model: edges since reset, raw button samples per edge, mode and cycles since mode start.
    int         n;
    bit         s_hist[$];
    bit         lvl;
    bit         armed;
    bit         press_pend;
    int         mmode;
    int         m;
    logic [3:0] exp_led;
    logic [1:0] exp_mode;

    function automatic bit samp(input int j);
        if (j < 1) return 1'b1;
        return s_hist[j-1];
    endfunction

    function automatic logic [3:0] mled(input int md, input int mm);
        int         k;
        int         bseq[6];
        logic [3:0] one;
        bseq = '{0, 1, 2, 3, 2, 1};
        one  = 4'b0001;
        k    = mm / STEP;
        case (md)
            0:       return ~(one << (k % 4));
            1:       return ~(one << (3 - (k % 4)));
            2:       return ~(one << bseq[k % 6]);
            default: return ((k % 2) == 0) ? 4'b0000 : 4'b1111;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; s_hist.delete(); lvl = 1'b1; armed = 1'b0; press_pend = 1'b0;
        mmode = 0; m = 0;
    endtask

    task automatic model_edge(input bit b);
        bit p;
        n++;
        s_hist.push_back(b);
        exp_led  = mled(mmode, m);
        exp_mode = 2'(mmode);
        if (press_pend) begin
            mmode = (mmode + 1) % 4;
            m     = 0;
        end else begin
            m++;
        end
        p = 1'b0;
        if (samp(n-2) != lvl && samp(n-3) != lvl && samp(n-4) != lvl) begin
            lvl = samp(n-2);
            p   = (lvl == 1'b0) && armed;
        end
        if (n >= 3 && samp(n-2) == 1'b1) armed = 1'b1;
        press_pend = p;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic cyc(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            model_edge(intf.btn1);
            @(negedge clk);
            check4("led", intf.led, exp_led);
            check4("mode", {2'b00, intf.mode}, {2'b00, exp_mode});
        end
    endtask

    task automatic press_btn(input int low_cycles, input int high_cycles);
        intf.btn1 = 1'b0;
        cyc(low_cycles);
        intf.btn1 = 1'b1;
        cyc(high_cycles);
    endtask

    initial begin
        reset     = 1'b0;
        intf.btn1 = 1'b1;
        repeat (2) @(negedge clk);
        check4("reset_led", intf.led, 4'b1111);
        check4("reset_mode", {2'b00, intf.mode}, 4'b0000);

        reset = 1'b1;
        model_reset();
        cyc(1);
        check4("first_led", intf.led, 4'b1110);
        cyc(20);

        press_btn(2, 12);
        check4("glitch_mode", {2'b00, intf.mode}, 4'b0000);

        press_btn(20, 1);
        check4("press_mode", {2'b00, intf.mode}, 4'b0001);
        cyc(8);

        press_btn(8, 30);
        check4("bounce_mode", {2'b00, intf.mode}, 4'b0010);
        press_btn(8, 20);
        check4("blink_mode", {2'b00, intf.mode}, 4'b0011);
        press_btn(8, 4);
        check4("wrap_mode", {2'b00, intf.mode}, 4'b0000);
        cyc(6);

        // Drop the button so the press pulse lands on the tick edge.
        for (int i = 0; i < 8 && (m % STEP) != 2; i++) cyc(1);
        press_btn(8, 14);
        check4("coincide_mode", {2'b00, intf.mode}, 4'b0001);

        for (int r = 0; r < 40; r++) begin
            intf.btn1 = 1'b0;
            cyc($urandom_range(1, 9));
            intf.btn1 = 1'b1;
            cyc($urandom_range(1, 9));
        end

        intf.btn1 = 1'b0;
        cyc(6);
        #2 reset = 1'b0;
        #1;
        check4("async_led", intf.led, 4'b1111);
        check4("async_mode", {2'b00, intf.mode}, 4'b0000);
        repeat (2) @(negedge clk);
        check4("hold_led", intf.led, 4'b1111);
        reset = 1'b1;
        model_reset();
        cyc(24);
        check4("no_press_mode", {2'b00, intf.mode}, 4'b0000);

        press_btn(1, 6);
        press_btn(10, 10);
        check4("rearm_mode", {2'b00, intf.mode}, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 50_000_000: clock cycles per pattern step (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: cycles btn1 must be stable before a change is accepted (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port btn1  input  1  mode button, active-low and asynchronous to clk.
REQ-006 SHALL have port led  output  4  LED drive, active-low (0 = lit), registered.
REQ-007 SHALL have port mode  output  2  current mode (0 RIGHT, 1 LEFT, 2 BOUNCE, 3 BLINK), registered.

Function
REQ-008 SHALL synchronise btn1 through two flops before any other use.
REQ-009 SHALL accept a new debounced level only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch restarts the count and is ignored.
REQ-010 SHALL generate a one-cycle press pulse on a debounced 1->0 transition; a held button SHALL give exactly one pulse, and release SHALL give none.
REQ-011 SHALL assert the press pulse no later than DEBOUNCE_CYCLES+3 cycles after btn1 falls and then stays low.
REQ-012 SHALL run a step counter 0..STEP_CYCLES-1 that wraps to 0, with width $clog2(STEP_CYCLES); a tick occurs in the cycle where the counter equals STEP_CYCLES-1.
REQ-013 SHALL implement the mode FSM RIGHT -> LEFT -> BOUNCE -> BLINK -> RIGHT, advancing one state per press pulse.
REQ-014 SHALL, on a press, clear the step counter and load the start position of the new mode in the same edge: RIGHT pos=0; LEFT pos=3; BOUNCE pos=0 with direction up; BLINK phase=on.
REQ-015 SHALL, in RIGHT on each tick, increment pos, with 3 wrapping to 0.
REQ-016 SHALL, in LEFT on each tick, decrement pos, with 0 wrapping to 3.
REQ-017 SHALL, in BOUNCE on each tick, step pos in the current direction and reverse at the ends, giving the sequence 0,1,2,3,2,1,0,1,...; no end value is repeated.
REQ-018 SHALL, in BLINK on each tick, toggle the phase: on gives led=4'b0000, off gives led=4'b1111.
REQ-019 SHALL, in RIGHT, LEFT and BOUNCE, drive exactly led[pos]=0 and all other bits 1.
REQ-020 SHALL register led and mode from the current state, so they follow a state change by one cycle.
REQ-021 SHALL give a press that coincides with a tick priority: the mode change applies and the step is discarded.
REQ-022 SHALL hold pos and phase constant between ticks, with no glitches on led.

Reset
REQ-023 SHALL, while reset=0, force led=4'b1111, mode=RIGHT, pos=0, direction up, phase on, step counter 0, debounce counter 0, synchronisers and debounced level 1, and press pulse 0.
REQ-024 SHALL drive led=4'b1110 in the first cycle after reset deasserts, and SHALL start the first step period from counter 0.
REQ-025 SHALL, if reset asserts mid-operation (including mid-debounce), return every register to its REQ-023 value immediately, with no press pulse generated on release.

Structure
REQ-026 SHALL take the typedef e_mode {RIGHT, LEFT, BOUNCE, BLINK} and the constant LED_ALL_OFF=4'b1111 from the shared package led_ctrl_pkg.
REQ-027 SHALL implement synchronisation, debounce and press-pulse generation in the sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_n, press), instantiated once.
REQ-028 SHALL keep the step counter, mode FSM and LED decode in led_mode_ctrl.

Verification (STEP_CYCLES=4, DEBOUNCE_CYCLES=3)
REQ-029 SHALL check: reset released with btn1=1 -> led sequence 1110,1101,1011,0111,1110, with one change every 4 cycles and mode=0 throughout.
REQ-030 SHALL check: btn1 low for 2 cycles, then high -> no press and mode stays 0; btn1 low for 20 cycles -> exactly one press, mode=1, led=0111, then 1011 after 4 cycles.
REQ-031 SHALL check: from LEFT, press -> mode=2, led walks 1110,1101,1011,0111,1011,1101,1110.
REQ-032 SHALL check: press from BOUNCE -> mode=3, led alternates 0000/1111 every 4 cycles; one further press -> mode=0, led=1110.
REQ-033 SHALL check: a press pulse that coincides with a tick -> mode advances, start position is shown, and the next change occurs exactly 4 cycles later.
REQ-034 SHALL check: reset asserted asynchronously mid-step with btn1 held low -> led=1111 and mode=0 immediately; after release with btn1 still low, no press occurs.
